// File: rtl/fetch_queue_if.sv
// ----------------------------------------------------------------------------
// fetch_queue_if
// Instruction-memory request/response bundle used by fetch_queue.
//   imem_req   : request valid, driven by the fetch unit (master)
//   imem_addr  : request address, held stable while imem_req is high
//   imem_ack   : response valid, driven by the memory (slave)
//   imem_rdata : fetched word, valid in the same cycle as imem_ack
// ----------------------------------------------------------------------------
interface fetch_queue_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_ack;
    logic [DATA_WIDTH-1:0] imem_rdata;

    modport master (output imem_req, output imem_addr,
                    input  imem_ack, input  imem_rdata);
    modport slave  (input  imem_req, input  imem_addr,
                    output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
// Fetch stage with its own program counter, a req/ack instruction-memory
// port and a DEPTH-entry prefetch queue of {instruction, PC+PC_STEP} feeding
// decode. Decode redirects flush the queue and squash any in-flight fetch.
//
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   pc_branch_d, pc_src_d   : redirect target and one-cycle redirect strobe
//   stall_f                 : decode not accepting; head entry is held
//   imem (master modport)   : imem_req/imem_addr out, imem_ack/imem_rdata in
//   valid_f                 : queue head valid
//   instruction_f           : queue head instruction
//   pc_plus_4_f             : queue head PC+PC_STEP
//   misalign_f              : sticky misaligned-redirect flag (optional)
//
// Optional feature: define FETCH_MISALIGN_TRAP_EN to add misalign_f and the
// HALT state entered on a redirect to a target with non-zero low two bits.
// ----------------------------------------------------------------------------
module fetch_queue #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
    parameter int                    PC_STEP    = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] pc_branch_d,
    input  logic                  pc_src_d,
    input  logic                  stall_f,
    fetch_queue_if.master         imem,
    output logic                  valid_f,
    output logic [DATA_WIDTH-1:0] instruction_f,
    output logic [ADDR_WIDTH-1:0] pc_plus_4_f
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_f
`endif
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] STEP_C  = ADDR_WIDTH'(PC_STEP);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [1:0] ST_HALT = 2'd3;
`endif

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  run_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [ADDR_WIDTH-1:0] pc4_q  [DEPTH];
    logic                  issue, push, pop;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic                  misalign_q, misalign_d;
`endif

    // Pop is suppressed by a redirect, which flushes the queue instead.
    assign pop = valid_f && !stall_f && !pc_src_d;

    // ---------------------------------------------------------------- FSM --
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        issue      = 1'b0;
        push       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pc_src_d) begin
                    fetch_pc_d = pc_branch_d;
                end else if (run_q && (count_q < DEPTH_C)) begin
                    // The slot is reserved now, so the response can always
                    // be pushed however long decode stalls.
                    issue   = 1'b1;
                    addr_d  = fetch_pc_q;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (pc_src_d) begin
                    fetch_pc_d = pc_branch_d;
                    state_d    = imem.imem_ack ? ST_IDLE : ST_DROP;
                end else if (imem.imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + STEP_C;
                    state_d    = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (pc_src_d) fetch_pc_d = pc_branch_d;
                if (imem.imem_ack) state_d = ST_IDLE;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            ST_HALT: ;
`endif
            default: state_d = ST_IDLE;
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d = misalign_q || (pc_src_d && (pc_branch_d[1:0] != 2'b00));
        // An outstanding fetch still drains through DROP; HALT is entered
        // whenever the machine would otherwise come back to IDLE.
        if (misalign_d && (state_d == ST_IDLE)) state_d = ST_HALT;
`endif
    end

    // -------------------------------------------------------- queue control --
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (pc_src_d) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            // Pointers are PTR_W bits wide, so they wrap modulo DEPTH.
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // -------------------------------------------------------------- state --
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_ADDR;
            addr_q     <= RESET_ADDR;
            run_q      <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values, independent of statement order.
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            // Keeps imem_req low for the first cycle out of reset.
            run_q      <= 1'b1;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // NOTE: the queue storage is reset too, so the head outputs read zero
    // after reset; with only DEPTH entries the reset cost is small.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                pc4_q[i]  <= '0;
            end
        end else if (push) begin
            data_q[wr_ptr_q] <= imem.imem_rdata;
            pc4_q[wr_ptr_q]  <= fetch_pc_q + STEP_C;
        end
    end

    // ------------------------------------------------------------ outputs --
    // The request is combinational in IDLE so a redirect target can be
    // presented the cycle after the redirect; WAIT/DROP hold the latched one.
    assign imem.imem_req  = issue || (state_q == ST_WAIT) || (state_q == ST_DROP);
    assign imem.imem_addr = (state_q == ST_IDLE) ? fetch_pc_q : addr_q;

    assign valid_f       = (count_q != '0);
    assign instruction_f = data_q[rd_ptr_q];
    assign pc_plus_4_f   = pc4_q[rd_ptr_q];
`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_f    = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_fetch_queue
// Self-checking bench for fetch_queue (DEPTH = 4) with a latency-programmable
// memory model returning addr ^ 32'hA5A5_0000. Inputs change on the falling
// edge; outputs are compared 1 ns later.
// ----------------------------------------------------------------------------
module tb_fetch_queue;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] pc_branch_d = '0;
    logic        pc_src_d = 1'b0;
    logic        stall_f = 1'b0;
    logic        valid_f;
    logic [31:0] instruction_f;
    logic [31:0] pc_plus_4_f;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        misalign_f;
`endif

    fetch_queue_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) imem_bus ();

    fetch_queue #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(4),
        .RESET_ADDR(32'h0), .PC_STEP(4)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .pc_branch_d   (pc_branch_d),
        .pc_src_d      (pc_src_d),
        .stall_f       (stall_f),
        .imem          (imem_bus),
        .valid_f       (valid_f),
        .instruction_f (instruction_f),
        .pc_plus_4_f   (pc_plus_4_f)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .misalign_f    (misalign_f)
`endif
    );

    always #5 clock = ~clock;

    // ---------------------------------------------------------- memory model
    logic        mem_en = 1'b0;
    int          mem_lat = 1;
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    logic        man_ack = 1'b0;
    logic [31:0] man_rdata = '0;

    always @(posedge clock) begin
        if (!mem_en) begin
            mem_busy <= 1'b0;
        end else if (mem_busy) begin
            if (mem_cnt == mem_lat) mem_busy <= 1'b0;
            else                    mem_cnt  <= mem_cnt + 1;
        end else if (imem_bus.imem_req) begin
            mem_busy <= 1'b1;
            mem_cnt  <= 1;
            mem_addr <= imem_bus.imem_addr;
        end
    end

    assign imem_bus.imem_ack   = mem_en ? (mem_busy && (mem_cnt == mem_lat)) : man_ack;
    assign imem_bus.imem_rdata = mem_en ? (mem_addr ^ 32'hA5A5_0000) : man_rdata;

    // ------------------------------------------------------------- checking
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset(input int lat);
        @(negedge clock);
        reset_n     = 1'b0;
        mem_en      = 1'b0;
        man_ack     = 1'b0;
        stall_f     = 1'b0;
        pc_src_d    = 1'b0;
        pc_branch_d = '0;
        repeat (2) @(posedge clock);
        #2;
        mem_lat = lat;
        mem_en  = 1'b1;
        reset_n = 1'b1;
    endtask

    // Next cycle: drive inputs on the falling edge, settle, then compare.
    task automatic step(input logic stall, input logic src, input logic [31:0] tgt);
        @(negedge clock);
        stall_f     = stall;
        pc_src_d    = src;
        pc_branch_d = tgt;
        #1;
    endtask

    typedef struct {
        logic        rst;
        int          lat;
        logic        stall;
        logic        src;
        logic [31:0] tgt;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc4;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input int lat, input logic stall, input logic src,
                       input logic [31:0] tgt, input logic e_req, input logic [31:0] e_addr,
                       input logic e_valid, input logic [31:0] e_pc4, input logic [31:0] e_instr);
        vec_t v;
        v = '{rst, lat, stall, src, tgt, e_req, e_addr, e_valid, e_pc4, e_instr};
        vecs.push_back(v);
    endtask

    initial begin
        int acks;

        // Streaming with a 1-cycle memory: 2 cycles per word.
        add(1, 1, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0);
        add(0, 1, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0,   32'h0);
        add(0, 1, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0,   32'h0);
        add(0, 1, 0, 0, 32'h0,   1, 32'h4,   1, 32'h4,   32'hA5A5_0000);
        add(0, 1, 0, 0, 32'h0,   1, 32'h4,   0, 32'h0,   32'h0);
        add(0, 1, 0, 0, 32'h0,   1, 32'h8,   1, 32'h8,   32'hA5A5_0004);
        add(0, 1, 0, 0, 32'h0,   1, 32'h8,   0, 32'h0,   32'h0);
        add(0, 1, 0, 0, 32'h0,   1, 32'hC,   1, 32'hC,   32'hA5A5_0008);
        // 3-cycle memory, redirect to 0x100 in the first WAIT cycle.
        add(1, 3, 0, 0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0);
        add(0, 3, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0,   32'h0);
        add(0, 3, 0, 1, 32'h100, 1, 32'h0,   0, 32'h0,   32'h0);
        add(0, 3, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0,   32'h0);
        add(0, 3, 0, 0, 32'h0,   1, 32'h0,   0, 32'h0,   32'h0);
        add(0, 3, 0, 0, 32'h0,   1, 32'h100, 0, 32'h0,   32'h0);
        add(0, 3, 0, 0, 32'h0,   1, 32'h100, 0, 32'h0,   32'h0);
        add(0, 3, 0, 0, 32'h0,   1, 32'h100, 0, 32'h0,   32'h0);
        add(0, 3, 0, 0, 32'h0,   1, 32'h100, 0, 32'h0,   32'h0);
        add(0, 3, 0, 0, 32'h0,   1, 32'h104, 1, 32'h104, 32'hA5A5_0100);

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset(vecs[i].lat);
            step(vecs[i].stall, vecs[i].src, vecs[i].tgt);
            if (vecs[i].rst) begin
                check($sformatf("v%0d reset instruction_f", i), instruction_f, 32'h0);
                check($sformatf("v%0d reset pc_plus_4_f", i), pc_plus_4_f, 32'h0);
            end
            check($sformatf("v%0d imem_req", i), {31'b0, imem_bus.imem_req}, {31'b0, vecs[i].e_req});
            check($sformatf("v%0d imem_addr", i), imem_bus.imem_addr, vecs[i].e_addr);
            check($sformatf("v%0d valid_f", i), {31'b0, valid_f}, {31'b0, vecs[i].e_valid});
            if (vecs[i].e_valid) begin
                check($sformatf("v%0d pc_plus_4_f", i), pc_plus_4_f, vecs[i].e_pc4);
                check($sformatf("v%0d instruction_f", i), instruction_f, vecs[i].e_instr);
            end
        end

        // Stall from reset: queue fills with 4 entries, then requests stop.
        do_reset(1);
        acks = 0;
        for (int c = 0; c <= 20; c++) begin
            step(1, 0, 32'h0);
            if (imem_bus.imem_ack) acks++;
            if (c >= 9) begin
                check($sformatf("stall c%0d imem_req", c), {31'b0, imem_bus.imem_req}, 32'h0);
                check($sformatf("stall c%0d valid_f", c), {31'b0, valid_f}, 32'h1);
                check($sformatf("stall c%0d pc_plus_4_f", c), pc_plus_4_f, 32'h4);
            end
        end
        check("stall push count", acks, 32'd4);
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 32'h0);
            check($sformatf("drain %0d valid_f", k), {31'b0, valid_f}, 32'h1);
            check($sformatf("drain %0d pc_plus_4_f", k), pc_plus_4_f, 32'(4 * (k + 1)));
            check($sformatf("drain %0d instruction_f", k), instruction_f, 32'hA5A5_0000 ^ 32'(4 * k));
        end

        // Redirect together with an ack and a pop while three entries wait.
        do_reset(1);
        for (int c = 0; c < 8; c++) step(1, 0, 32'h0);
        step(0, 1, 32'h200);
        check("coincide imem_ack", {31'b0, imem_bus.imem_ack}, 32'h1);
        step(0, 0, 32'h0);
        check("coincide valid_f", {31'b0, valid_f}, 32'h0);
        check("coincide imem_req", {31'b0, imem_bus.imem_req}, 32'h1);
        check("coincide imem_addr", imem_bus.imem_addr, 32'h200);
        step(0, 0, 32'h0);
        check("coincide wait valid_f", {31'b0, valid_f}, 32'h0);
        step(0, 0, 32'h0);
        check("coincide first valid_f", {31'b0, valid_f}, 32'h1);
        check("coincide first pc_plus_4_f", pc_plus_4_f, 32'h204);
        check("coincide first instruction_f", instruction_f, 32'hA5A5_0200);

        // Asynchronous reset in the middle of a WAIT.
        do_reset(3);
        step(0, 0, 32'h0);
        step(0, 0, 32'h0);
        step(0, 0, 32'h0);
        check("midwait pre imem_req", {31'b0, imem_bus.imem_req}, 32'h1);
        #2;
        reset_n = 1'b0;
        mem_en  = 1'b0;
        #1;
        check("async rst imem_req", {31'b0, imem_bus.imem_req}, 32'h0);
        check("async rst imem_addr", imem_bus.imem_addr, 32'h0);
        check("async rst valid_f", {31'b0, valid_f}, 32'h0);
        repeat (2) @(posedge clock);
        #2;
        reset_n = 1'b1;
        step(0, 0, 32'h0);
        check("post rst imem_req", {31'b0, imem_bus.imem_req}, 32'h0);
        @(negedge clock);
        man_ack   = 1'b1;
        man_rdata = 32'hDEAD_0000;
        #1;
        check("post rst first imem_req", {31'b0, imem_bus.imem_req}, 32'h1);
        check("post rst first imem_addr", imem_bus.imem_addr, 32'h0);
        @(negedge clock);
        man_rdata = 32'h0000_1234;
        #1;
        check("stale ack ignored valid_f", {31'b0, valid_f}, 32'h0);
        @(negedge clock);
        man_ack = 1'b0;
        #1;
        check("post rst valid_f", {31'b0, valid_f}, 32'h1);
        check("post rst pc_plus_4_f", pc_plus_4_f, 32'h4);
        check("post rst instruction_f", instruction_f, 32'h0000_1234);

`ifdef FETCH_MISALIGN_TRAP_EN
        // Misaligned redirect traps until reset.
        do_reset(1);
        step(0, 1, 32'h102);
        check("misalign before", {31'b0, misalign_f}, 32'h0);
        for (int c = 0; c < 10; c++) begin
            step(0, 0, 32'h0);
            check($sformatf("misalign c%0d flag", c), {31'b0, misalign_f}, 32'h1);
            check($sformatf("misalign c%0d imem_req", c), {31'b0, imem_bus.imem_req}, 32'h0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
